// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide opcodes, the
// multiply/divide FSM state type and small opcode-decoding helpers.
package mips_pkg;

    localparam logic [2:0] MD_OP_MULTU = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_DIVU  = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Opcodes 0..3 are the iterative arithmetic ops; 4..7 are moves or no-ops.
    function automatic logic md_op_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic md_op_is_div(input logic [2:0] op);
        return (op == MD_OP_DIVU) || (op == MD_OP_DIV);
    endfunction

    function automatic logic md_op_is_signed(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath: a right-shifting shift-add
// step for multiply or a left-shifting restoring-subtract step for divide.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The remainder stays below the divisor, so the trial difference always
    // fits in WIDTH bits whenever the subtraction is accepted.
    always_comb begin
        addend  = q_in[0] ? {1'b0, operand} : '0;
        sum     = {1'b0, acc_in} + addend;
        shifted = {acc_in, q_in[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - operand;
        acc_out = sum[WIDTH:1];
        q_out   = {sum[0], q_in[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                acc_out = diff;
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = shifted[WIDTH-1:0];
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_hilo_unit.sv
// Iterative signed/unsigned multiply/divide unit with the architectural HI/LO
// registers, MTHI/MTLO writes, a Busy/Done handshake and pipeline flush.
module mul_div_hilo_unit
    import mips_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int N_STEPS = WIDTH / BITS_PER_CYC;
    localparam int CNT_W   = $clog2(N_STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_STEPS - 1);

    md_state_t state_q;
    md_state_t state_d;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] operand_q;
    logic             is_div_q;
    logic             res_neg_q;
    logic             rem_neg_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             dbz_q;

    logic load;
    logic commit;
    logic dbz_commit;
    logic mt_hi;
    logic mt_lo;

    logic             op_is_div;
    logic             op_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    logic [WIDTH-1:0] acc_chain [BITS_PER_CYC+1];
    logic [WIDTH-1:0] q_chain   [BITS_PER_CYC+1];

    assign op_is_div = md_op_is_div(Op);
    assign op_signed = md_op_is_signed(Op);
    assign a_abs     = (op_signed && DataA[WIDTH-1]) ? -DataA : DataA;
    assign b_abs     = (op_signed && DataB[WIDTH-1]) ? -DataB : DataB;

    assign acc_chain[0] = acc_q;
    assign q_chain[0]   = q_q;

    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : gen_step
        md_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (is_div_q),
            .acc_in  (acc_chain[i]),
            .q_in    (q_chain[i]),
            .operand (operand_q),
            .acc_out (acc_chain[i+1]),
            .q_out   (q_chain[i+1])
        );
    end

    // Sign correction is applied to the unsigned magnitude result only in FIX.
    assign prod       = {acc_q, q_q};
    assign prod_fixed = res_neg_q ? -prod : prod;
    assign quot_fixed = res_neg_q ? -q_q : q_q;
    assign rem_fixed  = rem_neg_q ? -acc_q : acc_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divide-by-zero and HI/LO moves complete straight from IDLE; Flush wins
    // over any Start and suppresses a commit that is still pending in FIX.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        commit     = 1'b0;
        dbz_commit = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && !Flush) begin
                    if (md_op_is_arith(Op)) begin
                        if (op_is_div && (DataB == '0)) begin
                            dbz_commit = 1'b1;
                        end else begin
                            load    = 1'b1;
                            state_d = RUN;
                        end
                    end else if (Op == MD_OP_MTHI) begin
                        mt_hi = 1'b1;
                    end else if (Op == MD_OP_MTLO) begin
                        mt_lo = 1'b1;
                    end
                end
            end
            RUN: begin
                if (Flush) begin
                    state_d = IDLE;
                end else if (count_q == LAST_COUNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                commit  = !Flush;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_q     <= '0;
            q_q       <= '0;
            operand_q <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= commit || dbz_commit;
            dbz_q  <= dbz_commit;
            if (load) begin
                is_div_q  <= op_is_div;
                res_neg_q <= op_signed && (DataA[WIDTH-1] ^ DataB[WIDTH-1]);
                rem_neg_q <= op_signed && op_is_div && DataA[WIDTH-1];
                count_q   <= '0;
                acc_q     <= '0;
                q_q       <= op_is_div ? a_abs : b_abs;
                operand_q <= op_is_div ? b_abs : a_abs;
            end else if (state_q == RUN) begin
                acc_q   <= acc_chain[BITS_PER_CYC];
                q_q     <= q_chain[BITS_PER_CYC];
                count_q <= count_q + CNT_W'(1);
            end
            if (commit) begin
                if (is_div_q) begin
                    hi_q <= rem_fixed;
                    lo_q <= quot_fixed;
                end else begin
                    hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fixed[WIDTH-1:0];
                end
            end else if (dbz_commit) begin
                hi_q <= DataA;
                lo_q <= '1;
            end else if (mt_hi) begin
                hi_q <= DataA;
            end else if (mt_lo) begin
                lo_q <= DataA;
            end
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HiOut     = hi_q;
    assign LoOut     = lo_q;

endmodule
